// File: rtl/mem_arb_pkg.sv
// Shared types for the scratch-memory port arbiter: FSM states, port ids, default widths.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_ASSERT,
        R_SAMPLE,
        RESP
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response handshake bundle between the two requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// 2-way grant from request valids; round-robin pointer moves to the other port on each accept.
// Combinational grant, 0 latency; MEM_ARB_FIXED_PRIO_EN makes port0 always win (no pointer).
module mem_rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req_valid,
    input  logic       i_accept,
    output logic [1:0] o_gnt,
    output logic       o_gnt_id
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, i_accept};

    always_comb begin
        o_gnt_id = i_req_valid[0] ? PORT0 : PORT1;
    end
`else
    logic r_rr_ptr;

    always_comb begin
        if (&i_req_valid) begin
            o_gnt_id = r_rr_ptr;
        end else begin
            o_gnt_id = i_req_valid[1] ? PORT1 : PORT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= PORT0;
        end else if (i_accept) begin
            r_rr_ptr <= ~o_gnt_id;
        end
    end
`endif

    assign o_gnt = (|i_req_valid) ? port_onehot(o_gnt_id) : 2'b00;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port sequencer for a tri-state scratch memory; read rsp 3 cycles after accept, write 3+WR_PULSE.
// Ready only in IDLE for the granted port (no queueing); MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WR_PULSE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_read,
    output logic                mem_write,
    inout  wire  [DATA_W-1:0]   mem_data
);

    localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    state_t              r_state;
    logic                r_port;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic [1:0]          w_gnt;
    logic                w_gnt_id;
    logic                w_accept;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    mem_rr_arbiter u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (bus.req_valid),
        .i_accept    (w_accept),
        .o_gnt       (w_gnt),
        .o_gnt_id    (w_gnt_id)
    );

    // rst_n gating keeps ready low while reset is held, even with valids asserted.
    assign bus.req_ready = ((r_state == IDLE) && rst_n) ? w_gnt : 2'b00;
    assign w_accept      = |(bus.req_valid & bus.req_ready);

    assign w_sel_we    = w_gnt_id ? bus.req_we[1]  : bus.req_we[0];
    assign w_sel_addr  = w_gnt_id ? bus.req_addr1  : bus.req_addr0;
    assign w_sel_wdata = w_gnt_id ? bus.req_wdata1 : bus.req_wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_port      <= PORT0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_drive     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port     <= w_gnt_id;
                        r_mem_addr <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        if (w_sel_we) begin
                            r_drive <= 1'b1;
                            r_state <= W_SETUP;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= R_ASSERT;
                        end
                    end
                end
                W_SETUP: begin
                    r_mem_write <= 1'b1;
                    r_cnt       <= CNT_W'(WR_PULSE - 1);
                    r_state     <= W_STROBE;
                end
                W_STROBE: begin
                    if (r_cnt == '0) begin
                        r_mem_write <= 1'b0;
                        r_state     <= W_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                W_HOLD: begin
                    r_drive     <= 1'b0;
                    r_rsp_valid <= port_onehot(r_port);
                    r_state     <= RESP;
                end
                R_ASSERT: begin
                    r_state <= R_SAMPLE;
                end
                R_SAMPLE: begin
                    r_mem_read  <= 1'b0;
                    r_rsp_rdata <= mem_data;
                    r_rsp_valid <= port_onehot(r_port);
                    r_state     <= RESP;
                end
                RESP: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_data      = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: real 32x8 tri-state memory, vector table, directed corner cases, random traffic.
module tb_mem_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int WP = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    wire  [DW-1:0] mem_data;

    logic [DW-1:0] tbmem   [0:31];
    logic [DW-1:0] ref_mem [0:31];
    logic [DW-1:0] last_rd;
    bit            mem_clr = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_PULSE(WP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_data  (mem_data)
    );

    assign mem_data = mem_read ? tbmem[mem_addr] : {DW{1'bz}};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) tbmem[i] <= '0;
        end else if (mem_write) begin
            tbmem[mem_addr] <= mem_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_port(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin
            ifc.req_we[1] = we; ifc.req_addr1 = a; ifc.req_wdata1 = d;
        end else begin
            ifc.req_we[0] = we; ifc.req_addr0 = a; ifc.req_wdata0 = d;
        end
    endtask

    // Issue one request on port p (called mid-cycle), then check bus timing, latency and response.
    task automatic issue(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int exp_lat, input logic [DW-1:0] exp_rd);
        int  n;
        int  lat;
        bit  got;
        drive_port(p, we, a, d);
        ifc.req_valid[p] = 1'b1;
        #1;
        n = 0;
        while (!ifc.req_ready[p] && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (!ifc.req_ready[p]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            ifc.req_valid = 2'b00;
            return;
        end
        @(posedge clk); #1;
        ifc.req_valid[p] = 1'b0;
        drive_port(p, 1'($urandom), AW'($urandom), DW'($urandom));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (we) begin
                if (lat == 1) begin
                    chk("wr_setup_strobe", mem_write, 1'b0);
                    chk("wr_addr", mem_addr, a);
                    chk("wr_setup_data", mem_data, d);
                end else if (lat <= 1 + WP) begin
                    chk("wr_strobe", mem_write, 1'b1);
                end else if (lat == 2 + WP) begin
                    chk("wr_hold_strobe", mem_write, 1'b0);
                    chk("wr_hold_data", mem_data, d);
                end
            end else if (lat <= 2) begin
                chk("rd_mem_read", mem_read, 1'b1);
                chk("rd_addr", mem_addr, a);
            end
            got = ifc.rsp_valid[p];
        end
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_other_port", ifc.rsp_valid[!p], 1'b0);
        chk("rsp_rdata", ifc.rsp_rdata, exp_rd);
        @(negedge clk);
        chk("rsp_one_cycle", ifc.rsp_valid[p], 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_rd = '0;
    endtask

    // Bus protocol watch: exclusive strobes, no contention on reads, write pulse width.
    initial begin : monitor
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("bus_rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
                if (mem_read) chk("bus_rd_data", mem_data, tbmem[mem_addr]);
                if (mem_write) begin
                    run++;
                end else if (run != 0) begin
                    chk("wr_pulse_len", run, WP);
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit            p;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            lat;
        logic [DW-1:0] rd;
    } vec_t;

    initial begin : main
        vec_t          vecs[8];
        bit            exp_seq[8];
        int            k, rem0, rem1, c0, c1;
        logic [DW-1:0] prd;
        bit            rp, rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rdat;

        vecs[0] = '{1'b0, 1'b1, 5'd5,  8'hA5, 4, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 5'd5,  8'h00, 3, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 5'd31, 8'hFF, 4, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 5'd0,  8'h00, 4, 8'hA5};
        vecs[4] = '{1'b0, 1'b0, 5'd31, 8'h00, 3, 8'hFF};
        vecs[5] = '{1'b1, 1'b0, 5'd0,  8'h00, 3, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 5'd5,  8'h3C, 4, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 5'd5,  8'h00, 3, 8'h3C};

`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        ifc.req_valid  = 2'b11;
        ifc.req_we     = 2'b00;
        ifc.req_addr0  = '0;
        ifc.req_addr1  = '0;
        ifc.req_wdata0 = '0;
        ifc.req_wdata1 = '0;
        last_rd = '0;

        // Reset values, with both valids asserted during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", ifc.req_ready, 2'b00);
        chk("rst_rsp_valid", ifc.rsp_valid, 2'b00);
        chk("rst_rsp_rdata", ifc.rsp_rdata, 8'h00);
        chk("rst_mem_addr", mem_addr, 5'd0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        ifc.req_valid = 2'b00;
        mem_clr = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].rd);
            if (vecs[i].we) ref_mem[vecs[i].a] = vecs[i].d;
            else            last_rd = vecs[i].rd;
        end

        // Both ports streaming reads straight out of reset.
        do_reset();
        ifc.req_we = 2'b00;
        ifc.req_addr0 = 5'd1;
        ifc.req_addr1 = 5'd2;
        k = 0; rem0 = 4; rem1 = 4;
        for (int c = 0; c < 200 && k < 8; c++) begin
            ifc.req_valid = {rem1 > 0, rem0 > 0};
            @(negedge clk);
            if (ifc.req_ready != 2'b00) begin
                chk("arb_grant", ifc.req_ready, exp_seq[k] ? 2'b10 : 2'b01);
                if (ifc.req_ready[1]) rem1--; else rem0--;
                k++;
            end
            @(posedge clk); #1;
        end
        ifc.req_valid = 2'b00;
        chk("arb_all_granted", k, 8);
        repeat (6) @(posedge clk);
        #1;
        last_rd = '0;

        // Reset while the write strobe is high.
        issue(1'b0, 1'b1, 5'd9, 8'h11, 3 + WP, last_rd);
        ref_mem[9] = 8'h11;
        drive_port(1'b1, 1'b1, 5'd9, 8'h77);
        ifc.req_valid = 2'b10;
        #1;
        chk("rst_mid_accept_ready", ifc.req_ready, 2'b10);
        @(posedge clk); #1;
        ifc.req_valid = 2'b00;
        @(posedge clk); #1;
        chk("rst_mid_strobe_high", mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobe_drop", mem_write, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_rd = '0;
        c1 = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.rsp_valid != 2'b00) c1++;
        end
        chk("rst_mid_no_rsp", c1, 0);
        #1;
        issue(1'b1, 1'b0, 5'd9, 8'h00, 3, 8'h11);
        last_rd = 8'h11;

        // One-cycle port1 pulse while port0 read is in flight.
        drive_port(1'b0, 1'b0, 5'd5, 8'h00);
        ifc.req_valid = 2'b01;
        #1;
        chk("pulse_p0_ready", ifc.req_ready, 2'b01);
        @(posedge clk); #1;
        drive_port(1'b1, 1'b1, 5'd5, 8'hEE);
        ifc.req_valid = 2'b10;
        @(negedge clk);
        chk("pulse_p1_not_ready", ifc.req_ready, 2'b00);
        @(posedge clk); #1;
        ifc.req_valid = 2'b00;
        c0 = 0; c1 = 0; prd = '0;
        repeat (8) begin
            @(negedge clk);
            if (ifc.rsp_valid[0]) begin c0++; prd = ifc.rsp_rdata; end
            if (ifc.rsp_valid[1]) c1++;
        end
        chk("pulse_p0_rsp_count", c0, 1);
        chk("pulse_p1_rsp_count", c1, 0);
        chk("pulse_p0_rdata", prd, 8'h3C);
        last_rd = 8'h3C;
        #1;
        issue(1'b1, 1'b0, 5'd5, 8'h00, 3, 8'h3C);

        // Random single-port traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            rp   = 1'($urandom);
            rw   = 1'($urandom);
            ra   = AW'($urandom_range(0, 7));
            rdat = DW'($urandom);
            issue(rp, rw, ra, rdat, rw ? 3 + WP : 3, rw ? last_rd : ref_mem[ra]);
            if (rw) ref_mem[ra] = rdat;
            else    last_rd = ref_mem[ra];
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
